// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN frame sequencer.
//   PIX_PER_IMG : pixels streamed into the core per MNIST image (28x28)
//   IMG_PIX_W   : pixel width
//   DEC_W       : width of the core decision / label
//   state_t     : sequencer state encoding
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int PIX_PER_IMG = 784;
    localparam int IMG_PIX_W   = 8;
    localparam int DEC_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRST   = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/cnn_seq_timer.sv
// -----------------------------------------------------------------------------
// cnn_seq_timer
// Loadable down-counter shared by the core-reset, pixel-stream and
// result-timeout intervals. A load takes priority; otherwise the count
// decrements once per cycle and parks at zero.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_load      : load i_load_val this cycle
//   i_load_val  : value to load
//   o_count     : current count
//   o_zero      : count is zero
// -----------------------------------------------------------------------------
module cnn_seq_timer
    import cnn_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_frame_sequencer
// Runs the CNN core over a batch of images: for each image it pulses the core
// soft reset, reads the label, streams PIX_PER_IMG pixels from pixel memory
// into the core one per cycle, waits (bounded) for the core decision, then
// reports the result and accumulates hit / image counts.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   start, num_imgs                : batch start request and batch size
//   busy, done                     : batch in progress, end-of-batch pulse
//   mem_rd_en, mem_addr, mem_rdata : pixel memory (1-cycle read latency)
//   lbl_rd_en, lbl_addr, lbl_rdata : label memory (1-cycle read latency)
//   core_rst_n, core_data_in       : core soft reset and pixel stream
//   core_valid_out, core_decision  : core result
//   res_valid, res_decision, res_hit : per-image result
//   hit_count, img_count, timeout_err : batch statistics
// -----------------------------------------------------------------------------
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_W   = 10,
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 4095,
    parameter int RST_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IMG_W-1:0]     num_imgs,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [IMG_PIX_W-1:0] mem_rdata,
    output logic                 lbl_rd_en,
    output logic [IMG_W-1:0]     lbl_addr,
    input  logic [DEC_W-1:0]     lbl_rdata,
    output logic                 core_rst_n,
    output logic [IMG_PIX_W-1:0] core_data_in,
    input  logic                 core_valid_out,
    input  logic [DEC_W-1:0]     core_decision,
    output logic                 res_valid,
    output logic [DEC_W-1:0]     res_decision,
    output logic                 res_hit,
    output logic [IMG_W-1:0]     hit_count,
    output logic [IMG_W-1:0]     img_count,
    output logic                 timeout_err
);

    localparam int TMR_MAX = (TIMEOUT > PIX_PER_IMG) ? TIMEOUT : PIX_PER_IMG;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] LD_RST = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] LD_PIX = TMR_W'(PIX_PER_IMG - 1);
    localparam logic [TMR_W-1:0] LD_TMO = TMR_W'(TIMEOUT);

    state_t                 r_state;
    state_t                 w_state_next;

    logic [IMG_W-1:0]       r_num_imgs;
    logic [IMG_W-1:0]       r_img_count;
    logic [IMG_W-1:0]       r_hit_count;
    logic                   r_timeout_err;
    logic [ADDR_W-1:0]      r_addr;
    logic [DEC_W-1:0]       r_label;
    logic                   r_lbl_dly;
    logic                   r_rd_dly;
    logic [DEC_W-1:0]       r_res_decision;
    logic                   r_res_hit;
    logic                   r_core_rst_n;
    logic                   r_done;

    logic                   w_tmr_load;
    logic [TMR_W-1:0]       w_tmr_load_val;
    logic [TMR_W-1:0]       w_tmr_count;
    logic                   w_tmr_zero;
    logic                   w_accept;
    logic                   w_wait_exit;
    logic                   w_timeout;
    logic                   w_hit;
    logic                   w_mem_rd_en;
    logic                   w_lbl_rd_en;

    cnn_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    assign w_mem_rd_en = (r_state == ST_STREAM);
    // The timer still holds its load value only on the first CRST cycle.
    assign w_lbl_rd_en = (r_state == ST_CRST) && (w_tmr_count == LD_RST);
    assign w_hit       = (core_decision == r_label);

    // ---------------------------------------------------------------------
    // Next-state logic and timer loads
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_accept       = 1'b0;
        w_wait_exit    = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (num_imgs == '0) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_state_next   = ST_CRST;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = LD_RST;
                    end
                end
            end
            ST_CRST: begin
                if (w_tmr_zero) begin
                    w_state_next   = ST_STREAM;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = LD_PIX;
                end
            end
            ST_STREAM: begin
                if (w_tmr_zero) begin
                    w_state_next   = ST_WAIT;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = LD_TMO;
                end
            end
            ST_WAIT: begin
                // The first WAIT cycle presents the last pixel, so loading
                // TIMEOUT here counts exactly TIMEOUT cycles after it.
                if (core_valid_out) begin
                    w_state_next = ST_RESULT;
                    w_wait_exit  = 1'b1;
                end else if (w_tmr_zero) begin
                    w_state_next = ST_RESULT;
                    w_wait_exit  = 1'b1;
                    w_timeout    = 1'b1;
                end
            end
            ST_RESULT: begin
                // img_count already includes the image just finished.
                if (r_img_count < r_num_imgs) begin
                    w_state_next   = ST_CRST;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = LD_RST;
                end else begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, address, label and scoreboard registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_num_imgs     <= '0;
            r_img_count    <= '0;
            r_hit_count    <= '0;
            r_timeout_err  <= 1'b0;
            r_addr         <= '0;
            r_label        <= '0;
            r_lbl_dly      <= 1'b0;
            r_rd_dly       <= 1'b0;
            r_res_decision <= '0;
            r_res_hit      <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            // Decoded from next state so the core sees reset low for
            // exactly the CRST cycles.
            r_core_rst_n <= (w_state_next != ST_CRST);
            r_done       <= (r_state == ST_FIN);
            r_rd_dly     <= w_mem_rd_en;
            r_lbl_dly    <= w_lbl_rd_en;

            if (r_lbl_dly) begin
                r_label <= lbl_rdata;
            end

            if (w_accept) begin
                r_num_imgs     <= num_imgs;
                r_img_count    <= '0;
                r_hit_count    <= '0;
                r_timeout_err  <= 1'b0;
                r_addr         <= '0;
                r_res_decision <= '0;
                r_res_hit      <= 1'b0;
            end

            // Running address continues across images: image k starts at k*784.
            if (w_mem_rd_en) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            if (w_wait_exit) begin
                r_img_count <= r_img_count + IMG_W'(1);
                if (w_timeout) begin
                    r_timeout_err  <= 1'b1;
                    r_res_decision <= '0;
                    r_res_hit      <= 1'b0;
                end else begin
                    r_res_decision <= core_decision;
                    r_res_hit      <= w_hit;
                    if (w_hit) begin
                        r_hit_count <= r_hit_count + IMG_W'(1);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign mem_rd_en    = w_mem_rd_en;
    assign mem_addr     = r_addr;
    assign lbl_rd_en    = w_lbl_rd_en;
    assign lbl_addr     = r_img_count;
    assign core_rst_n   = r_core_rst_n;
    // Read data arrives the cycle after each read; gate it so the stream
    // idles at zero between images.
    assign core_data_in = r_rd_dly ? mem_rdata : '0;
    assign res_valid    = (r_state == ST_RESULT);
    assign res_decision = r_res_decision;
    assign res_hit      = r_res_hit;
    assign hit_count    = r_hit_count;
    assign img_count    = r_img_count;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_frame_sequencer
// Directed bench with pixel/label memory models, a simple core model and a
// scoreboard of expected per-image results and end-of-batch statistics.
// -----------------------------------------------------------------------------
module tb_cnn_frame_sequencer;

    localparam int IMG_W    = 10;
    localparam int ADDR_W   = 20;
    localparam int TIMEOUT  = 4095;
    localparam int RST_CYC  = 2;
    localparam int PIX      = 784;
    localparam int CORE_DLY = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IMG_W-1:0]  num_imgs = '0;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = '0;
    logic              lbl_rd_en;
    logic [IMG_W-1:0]  lbl_addr;
    logic [3:0]        lbl_rdata = '0;
    logic              core_rst_n;
    logic [7:0]        core_data_in;
    logic              core_valid_out = 1'b0;
    logic [3:0]        core_decision = '0;
    logic              res_valid;
    logic [3:0]        res_decision;
    logic              res_hit;
    logic [IMG_W-1:0]  hit_count;
    logic [IMG_W-1:0]  img_count;
    logic              timeout_err;

    always #5 clk = ~clk;

    cnn_frame_sequencer #(
        .IMG_W   (IMG_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .RST_CYC (RST_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_imgs       (num_imgs),
        .busy           (busy),
        .done           (done),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .lbl_rd_en      (lbl_rd_en),
        .lbl_addr       (lbl_addr),
        .lbl_rdata      (lbl_rdata),
        .core_rst_n     (core_rst_n),
        .core_data_in   (core_data_in),
        .core_valid_out (core_valid_out),
        .core_decision  (core_decision),
        .res_valid      (res_valid),
        .res_decision   (res_decision),
        .res_hit        (res_hit),
        .hit_count      (hit_count),
        .img_count      (img_count),
        .timeout_err    (timeout_err)
    );

    // ---------------- memory and core models ----------------
    logic [3:0] lbl_tab [0:7];
    logic [3:0] dec_tab [0:7];
    logic       core_respond = 1'b1;
    logic       spur_valid = 1'b0;
    logic       rd_q = 1'b0;
    int         cd = 0;
    int         cm_img = 0;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr[7:0];
        if (lbl_rd_en) lbl_rdata <= lbl_tab[lbl_addr[2:0]];
    end

    // Core answers CORE_DLY cycles after the last pixel appears on core_data_in.
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_q           <= 1'b0;
            cd             <= 0;
            core_valid_out <= 1'b0;
        end else begin
            rd_q           <= mem_rd_en;
            core_valid_out <= spur_valid;
            if (spur_valid) core_decision <= 4'hE;
            if (start && !busy) cm_img <= 0;
            if (rd_q && !mem_rd_en) begin
                if (core_respond) cd <= CORE_DLY - 1;
            end else if (cd != 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    core_valid_out <= 1'b1;
                    core_decision  <= dec_tab[cm_img];
                    cm_img         <= cm_img + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [3:0] dec; logic hit; } res_t;
    typedef struct { int hits; int imgs; int terr; int nrd; int ncrst; } fin_t;

    res_t res_q[$];
    fin_t fin_q[$];
    res_t mon_r;
    fin_t mon_f;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int   exp_addr = 0;
    int   n_rd = 0;
    int   n_crst = 0;
    int   low_cnt = 0;
    logic rst_flag = 1'b1;
    logic prev_rd = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (start === 1'b1 && busy === 1'b0 && rst_n === 1'b1) begin
                exp_addr = 0;
                n_rd     = 0;
                n_crst   = 0;
            end
            if (mem_rd_en === 1'b1) begin
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                n_rd++;
            end
            if (rst_n === 1'b1)
                check("core_data_in", 32'(core_data_in), prev_rd ? 32'(prev_addr[7:0]) : 32'd0);
            prev_rd   = (mem_rd_en === 1'b1) && (rst_n === 1'b1);
            prev_addr = mem_addr;
            if (core_rst_n !== 1'b1) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (!rst_flag) begin
                    check("core_rst_len", 32'(low_cnt), 32'(RST_CYC));
                    n_crst++;
                end
                low_cnt  = 0;
                rst_flag = 1'b0;
            end
            if (res_valid === 1'b1) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL res_unexpected: got res_valid=1 expected 0");
                end else begin
                    mon_r = res_q.pop_front();
                    check("res_decision", 32'(res_decision), 32'(mon_r.dec));
                    check("res_hit", 32'(res_hit), 32'(mon_r.hit));
                    $display("result: decision=%0d hit=%0d", res_decision, res_hit);
                end
            end
            if (done === 1'b1) begin
                if (fin_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected 0");
                end else begin
                    mon_f = fin_q.pop_front();
                    check("hit_count", 32'(hit_count), 32'(mon_f.hits));
                    check("img_count", 32'(img_count), 32'(mon_f.imgs));
                    check("timeout_err", 32'(timeout_err), 32'(mon_f.terr));
                    check("pixel_reads", 32'(n_rd), 32'(mon_f.nrd));
                    check("core_rst_pulses", 32'(n_crst), 32'(mon_f.ncrst));
                    check("res_pending", 32'(res_q.size()), 32'd0);
                    $display("batch: hits=%0d imgs=%0d timeout_err=%0d", hit_count, img_count, timeout_err);
                end
            end
            if (rst_n !== 1'b1) begin
                rst_flag = 1'b1;
                exp_addr = 0;
                n_rd     = 0;
                n_crst   = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_res(input logic [3:0] d, input logic h);
        res_t r;
        r.dec = d;
        r.hit = h;
        res_q.push_back(r);
    endtask

    task automatic push_fin(input int h, input int i, input int t, input int nrd, input int nc);
        fin_t f;
        f.hits = h; f.imgs = i; f.terr = t; f.nrd = nrd; f.ncrst = nc;
        fin_q.push_back(f);
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start    = 1'b1;
        num_imgs = IMG_W'(n);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL wait_done: got done=%0b expected 1 within %0d cycles", done, max_cyc);
        end
    endtask

    task automatic chk_rst_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_lbl_rd_en"}, 32'(lbl_rd_en), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_hit"}, 32'(res_hit), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_lbl_addr"}, 32'(lbl_addr), 0);
        check({tag, "_core_data_in"}, 32'(core_data_in), 0);
        check({tag, "_res_decision"}, 32'(res_decision), 0);
        check({tag, "_hit_count"}, 32'(hit_count), 0);
        check({tag, "_img_count"}, 32'(img_count), 0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int k;
        for (int i = 0; i < 8; i++) begin
            lbl_tab[i] = '0;
            dec_tab[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_rst_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_core_rst_n", 32'(core_rst_n), 1);
        check("idle_busy", 32'(busy), 0);

        // Test 1: single image, label 7, decision 7
        lbl_tab[0] = 4'd7; dec_tab[0] = 4'd7; core_respond = 1'b1;
        push_res(4'd7, 1'b1);
        push_fin(1, 1, 0, PIX, 1);
        do_start(1);
        @(negedge clk);   // start cycle + 1
        check("t1_core_rst_n_c1", 32'(core_rst_n), 0);
        check("t1_lbl_rd_en_c1", 32'(lbl_rd_en), 1);
        check("t1_busy_c1", 32'(busy), 1);
        @(negedge clk);   // +2
        check("t1_core_rst_n_c2", 32'(core_rst_n), 0);
        check("t1_lbl_rd_en_c2", 32'(lbl_rd_en), 0);
        @(negedge clk);   // +3
        check("t1_mem_rd_en_c3", 32'(mem_rd_en), 1);
        check("t1_core_rst_n_c3", 32'(core_rst_n), 1);
        @(negedge clk);   // +4 = RST_CYC+2: pixel 0
        check("t1_pix0", 32'(core_data_in), 32'h00);
        @(negedge clk);   // pixel 1
        check("t1_pix1", 32'(core_data_in), 32'h01);
        wait_done(3000);

        // Test 2: three images, labels 1,2,3 decisions 1,5,3
        lbl_tab[0] = 4'd1; lbl_tab[1] = 4'd2; lbl_tab[2] = 4'd3;
        dec_tab[0] = 4'd1; dec_tab[1] = 4'd5; dec_tab[2] = 4'd3;
        push_res(4'd1, 1'b1);
        push_res(4'd5, 1'b0);
        push_res(4'd3, 1'b1);
        push_fin(2, 3, 0, 3 * PIX, 3);
        do_start(3);
        wait_done(6000);

        // Test 3: empty batch
        push_fin(0, 0, 0, 0, 0);
        do_start(0);
        @(negedge clk);
        check("t3_done_c1", 32'(done), 0);
        check("t3_busy_c1", 32'(busy), 1);
        @(negedge clk);
        check("t3_done_c2", 32'(done), 1);
        check("t3_core_rst_n", 32'(core_rst_n), 1);
        repeat (3) @(negedge clk);

        // Test 4: core never answers, two images time out
        core_respond = 1'b0;
        lbl_tab[0] = 4'd3; lbl_tab[1] = 4'd0;
        push_res(4'd0, 1'b0);
        push_res(4'd0, 1'b0);
        push_fin(0, 2, 1, 2 * PIX, 2);
        do_start(2);
        wait_done(12000);
        core_respond = 1'b1;

        // Test 5: start and spurious core_valid_out during STREAM are ignored
        lbl_tab[0] = 4'd4; lbl_tab[1] = 4'd9;
        dec_tab[0] = 4'd4; dec_tab[1] = 4'd9;
        push_res(4'd4, 1'b1);
        push_res(4'd9, 1'b1);
        push_fin(2, 2, 0, 2 * PIX, 2);
        do_start(2);
        k = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr == 300) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach_addr300", 32'(mem_addr), 300);
        @(posedge clk); #1;
        start = 1'b1; num_imgs = 10'd5; spur_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 spur_valid = 1'b0;
        wait_done(4000);

        // Test 6: reset mid-stream at pixel 400, then a clean batch
        lbl_tab[0] = 4'd7; dec_tab[0] = 4'd7;
        do_start(1);
        k = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr == 400) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_addr400", 32'(mem_addr), 400);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk_rst_vals("abort");
        repeat (200) @(negedge clk);
        push_res(4'd7, 1'b1);
        push_fin(1, 1, 0, PIX, 1);
        do_start(1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_restart_addr0", 32'(mem_addr), 0);
        wait_done(3000);

        repeat (5) @(negedge clk);
        check("res_queue_empty", 32'(res_q.size()), 0);
        check("fin_queue_empty", 32'(fin_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
